// File: rtl/uart_pkg.sv
// Shared UART definitions: the FSM state encoding used by uart_tx and uart_rx_16x, plus oversample constants.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int unsigned OS_RATE   = 16;
   localparam int unsigned MID_TICK  = 7;
   localparam int unsigned LAST_TICK = OS_RATE - 1;
   localparam int unsigned TICK_W    = $clog2(OS_RATE);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin; resets to the idle (high) line level.
module uart_rx_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver on a 16x oversample tick, LSB first, with one-clk rx_valid / frame_err strobes.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 2-of-3 vote over the last three ticks.
module uart_rx_16x
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 os_tick,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic                 rx_s;
   logic                 sample;
   uart_state_t          state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 armed_q, armed_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (rx),
      .rx_s (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // History shifts on every tick, so at the decision tick it holds the two preceding samples.
   logic [1:0] hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '1;
      end else if (os_tick) begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
   assign sample = rx_s;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      armed_d = armed_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      if (os_tick) begin
         case (state_q)
            IDLE: begin
               if (rx_s) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               if (tick_q == TICK_W'(MID_TICK)) begin
                  if (!sample) begin
                     state_d = DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            DATA: begin
               tick_d = tick_q + 1'b1;
               if (tick_q == TICK_W'(LAST_TICK)) begin
                  shift_d = {sample, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                     state_d = STOP;
                  end
               end
            end
            STOP: begin
               tick_d = tick_q + 1'b1;
               if (tick_q == TICK_W'(LAST_TICK)) begin
                  state_d = IDLE;
                  if (sample) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d  = 1'b1;
                     armed_d = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         armed_q <= 1'b1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         armed_q <= armed_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign rx_busy   = busy_q;

endmodule
